// File: rtl/free_list_ctrl.sv
// Free-tag FIFO for register renaming: hands out up to WAYS physical tags per cycle,
// reclaims tags superseded at retirement, and rolls back speculative allocation on except.
module free_list_ctrl #(
   parameter int unsigned WAYS = 4,
   parameter int unsigned PRF  = 64,
   parameter int unsigned ARF  = 32,
   localparam int unsigned TW  = $clog2(PRF),
   localparam int unsigned N   = PRF - ARF,
   localparam int unsigned IW  = $clog2(N),
   localparam int unsigned PW  = IW + 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               except,
   input  logic [WAYS-1:0]    alloc_req,
   output logic               alloc_grant,
   output logic [WAYS*TW-1:0] alloc_idx,
   input  logic [WAYS-1:0]    retire_en,
   input  logic [WAYS*TW-1:0] retire_old_idx,
   output logic [PW-1:0]      avail_cnt
);

   logic [TW-1:0] fifo_q [N];
   logic [TW-1:0] fifo_d [N];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] rhead_q, rhead_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW-1:0] avail_q, avail_d;

   logic [PW-1:0] r_cnt, k_cnt;
   logic [PW-1:0] alloc_slot [WAYS];
   logic [PW-1:0] ret_slot [WAYS];

   // Compacted slot per way: pointer plus number of enabled ways below it.
   always_comb begin
      r_cnt = '0;
      k_cnt = '0;
      for (int unsigned i = 0; i < WAYS; i++) begin
         alloc_slot[i] = head_q + r_cnt;
         ret_slot[i]   = tail_q + k_cnt;
         if (alloc_req[i]) r_cnt = r_cnt + PW'(1);
         if (retire_en[i]) k_cnt = k_cnt + PW'(1);
      end
   end

   for (genvar g = 0; g < WAYS; g++) begin : g_alloc_idx
      assign alloc_idx[g*TW +: TW] = fifo_q[alloc_slot[g][IW-1:0]];
   end

   assign alloc_grant = !reset && !except && (r_cnt <= avail_q);
   assign avail_cnt   = avail_q;

   always_comb begin
      fifo_d = fifo_q;
      for (int unsigned i = 0; i < WAYS; i++) begin
         if (retire_en[i]) fifo_d[ret_slot[i][IW-1:0]] = retire_old_idx[i*TW +: TW];
      end
      tail_d  = tail_q + k_cnt;
      rhead_d = rhead_q + k_cnt;
      head_d  = alloc_grant ? head_q + r_cnt : head_q;
      avail_d = avail_q - (alloc_grant ? r_cnt : '0) + k_cnt;
      // Flush: everything past the retired point goes back; tail-rhead == N keeps avail at N.
      if (except) begin
         head_d  = rhead_q + k_cnt;
         avail_d = PW'(N);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < N; i++) fifo_q[i] <= TW'(ARF + i);
         head_q  <= '0;
         rhead_q <= '0;
         tail_q  <= PW'(N);
         avail_q <= PW'(N);
      end else begin
         fifo_q  <= fifo_d;
         head_q  <= head_d;
         rhead_q <= rhead_d;
         tail_q  <= tail_d;
         avail_q <= avail_d;
      end
   end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Scoreboard bench for free_list_ctrl: a queue-based free-list model predicts grant,
// tags and avail_cnt; a monitor process compares them against the DUT every cycle.
module tb_free_list_ctrl;

   localparam int WAYS = 4;
   localparam int TW   = 6;
   localparam int N    = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              except = 1'b0;
   logic [WAYS-1:0]   alloc_req = '0;
   logic              alloc_grant;
   logic [WAYS*TW-1:0] alloc_idx;
   logic [WAYS-1:0]   retire_en = '0;
   logic [WAYS*TW-1:0] retire_old_idx = '0;
   logic [5:0]        avail_cnt;

   free_list_ctrl #(.WAYS(4), .PRF(64), .ARF(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .except         (except),
      .alloc_req      (alloc_req),
      .alloc_grant    (alloc_grant),
      .alloc_idx      (alloc_idx),
      .retire_en      (retire_en),
      .retire_old_idx (retire_old_idx),
      .avail_cnt      (avail_cnt)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        grant;
      logic [3:0]  mask;
      int          idx [WAYS];
      int          avail;
   } exp_t;

   exp_t exp_q [$];
   int   free_q [$];   // allocatable tags, oldest first
   int   spec_q [$];   // allocated tags not yet covered by a retirement
   int   n_cmp = 0;
   int   n_bad = 0;
   int   old_ctr = 0;
   bit   done = 0;

   function automatic void model_reset();
      free_q.delete();
      spec_q.delete();
      for (int i = 0; i < N; i++) free_q.push_back(32 + i);
   endfunction

   task automatic step(input logic [3:0] req, input logic [3:0] ren, input int olds [WAYS],
                       input logic exc, input logic rst);
      exp_t e;
      int   r;
      int   j;
      int   tmp [$];
      @(negedge clock);
      alloc_req = req;
      retire_en = ren;
      except    = exc;
      reset     = rst;
      for (int i = 0; i < WAYS; i++) retire_old_idx[i*TW +: TW] = TW'(olds[i]);
      r       = $countones(req);
      e.avail = free_q.size();
      e.grant = !rst && !exc && (r <= free_q.size());
      e.mask  = e.grant ? req : 4'b0;
      j = 0;
      for (int i = 0; i < WAYS; i++) begin
         e.idx[i] = -1;
         if (e.mask[i]) begin
            e.idx[i] = free_q[j];
            j++;
         end
      end
      exp_q.push_back(e);
      if (rst) begin
         model_reset();
      end else begin
         if (e.grant) for (int i = 0; i < r; i++) spec_q.push_back(free_q.pop_front());
         for (int i = 0; i < WAYS; i++) begin
            if (ren[i]) begin
               if (spec_q.size() > 0) void'(spec_q.pop_front());
               tmp.push_back(olds[i]);
            end
         end
         if (exc) begin
            free_q = {spec_q, free_q};
            spec_q.delete();
         end
         foreach (tmp[i]) free_q.push_back(tmp[i]);
      end
   endtask

   // Monitor: sample mid-cycle, well after inputs settle and before the next edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (alloc_grant !== e.grant) begin
               n_bad++;
               $display("FAIL grant @%0t: got %b want %b", $time, alloc_grant, e.grant);
            end
            n_cmp++;
            if (int'(avail_cnt) != e.avail || $isunknown(avail_cnt)) begin
               n_bad++;
               $display("FAIL avail_cnt @%0t: got %0d want %0d", $time, avail_cnt, e.avail);
            end
            for (int i = 0; i < WAYS; i++) begin
               if (e.mask[i]) begin
                  n_cmp++;
                  if (int'(alloc_idx[i*TW +: TW]) != e.idx[i]) begin
                     n_bad++;
                     $display("FAIL alloc_idx[%0d] @%0t: got %0d want %0d", i, $time,
                              alloc_idx[i*TW +: TW], e.idx[i]);
                  end
               end
            end
         end
      end
   end

   initial begin
      int z [WAYS] = '{0, 0, 0, 0};
      int o [WAYS];
      logic [3:0] req, ren;
      logic exc;
      int cnt;
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Fresh allocation, then drain to the empty boundary.
      step(4'b1111, 4'b0, z, 1'b0, 1'b0);
      step(4'b1010, 4'b0, z, 1'b0, 1'b0);
      repeat (6) step(4'b1111, 4'b0, z, 1'b0, 1'b0);
      step(4'b0001, 4'b0, z, 1'b0, 1'b0);
      step(4'b0011, 4'b0, z, 1'b0, 1'b0);
      step(4'b0011, 4'b0, z, 1'b0, 1'b0);
      step(4'b0001, 4'b0, z, 1'b0, 1'b0);
      // Empty: retired tag is not bypassed, appears next cycle.
      step(4'b0001, 4'b0001, '{5, 0, 0, 0}, 1'b0, 1'b0);
      step(4'b0001, 4'b0, z, 1'b0, 1'b0);

      // Rollback on except with a concurrent retire.
      step(4'b0000, 4'b0, z, 1'b0, 1'b1);
      step(4'b1111, 4'b0, z, 1'b0, 1'b0);
      step(4'b1111, 4'b0, z, 1'b0, 1'b0);
      step(4'b0000, 4'b0011, '{3, 7, 0, 0}, 1'b0, 1'b0);
      step(4'b1111, 4'b0001, '{9, 0, 0, 0}, 1'b1, 1'b0);
      repeat (9) step(4'b1111, 4'b0, z, 1'b0, 1'b0);

      // Reset mid-stream with a full request.
      step(4'b1111, 4'b0, z, 1'b0, 1'b1);
      step(4'b0001, 4'b0, z, 1'b0, 1'b0);

      // Steady alloc/retire rounds across the index wrap.
      step(4'b0111, 4'b0, z, 1'b0, 1'b0);
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < WAYS; i++) begin
            o[i] = old_ctr;
            old_ctr = (old_ctr + 1) % 64;
         end
         step(4'b1111, 4'b1111, o, 1'b0, 1'b0);
      end

      // Randomized traffic with occasional flushes.
      for (int n = 0; n < 400; n++) begin
         req = 4'($urandom);
         ren = 4'($urandom);
         cnt = 0;
         for (int i = 0; i < WAYS; i++) begin
            if (ren[i]) begin
               if (cnt < spec_q.size()) cnt++;
               else ren[i] = 1'b0;
            end
            o[i] = old_ctr;
            old_ctr = (old_ctr + 1) % 64;
         end
         exc = ($urandom_range(0, 19) == 0);
         step(req, ren, o, exc, ($urandom_range(0, 199) == 0));
      end

      step(4'b0000, 4'b0, z, 1'b0, 1'b0);
      repeat (3) @(negedge clock);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
